// File: rtl/l1_mem_arbiter.sv
// Shares the single-ported next-level memory bus between I-cache line refills
// (fixed-length bursts) and single-word D-cache accesses.
module l1_mem_arbiter #(
   parameter int BLOCK_WORDS   = 4,
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int MAX_DC_STREAK = 4
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           ic_req_i,
   input  logic [ADDR_W-1:0]              ic_addr_i,
   input  logic                           ic_abort_i,
   output logic                           ic_rvalid_o,
   output logic [$clog2(BLOCK_WORDS)-1:0] ic_word_idx_o,
   output logic                           ic_done_o,
   input  logic                           dc_req_i,
   input  logic                           dc_we_i,
   input  logic [ADDR_W-1:0]              dc_addr_i,
   input  logic [DATA_W-1:0]              dc_wdata_i,
   output logic                           dc_done_o,
   output logic [DATA_W-1:0]              rdata_o,
   output logic                           mem_req_o,
   output logic                           mem_we_o,
   output logic [ADDR_W-1:0]              mem_addr_o,
   output logic [DATA_W-1:0]              mem_wdata_o,
   input  logic                           mem_ack_i,
   input  logic [DATA_W-1:0]              mem_rdata_i
);

   localparam int IDX_W    = $clog2(BLOCK_WORDS);
   localparam int OFF_W    = IDX_W + 2;
   localparam int STREAK_W = $clog2(MAX_DC_STREAK + 1);

   typedef enum logic [1:0] {
      IDLE,
      IC_BURST,
      DC_XFER,
      IC_ABORT
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_beat;
   logic [STREAK_W-1:0] r_streak;
   logic [ADDR_W-1:0]   r_line_base;
   logic [ADDR_W-1:0]   r_dc_addr;
   logic                r_dc_we;
   logic [DATA_W-1:0]   r_dc_wdata;

   logic                w_streak_full;
   logic                w_ic_grant;
   logic                w_beat_last;
   logic                w_ic_beat_ok;
   logic [ADDR_W-1:0]   w_beat_addr;
   logic                w_unused;

   assign w_streak_full = (r_streak == STREAK_W'(MAX_DC_STREAK));
   // A waiting I-cache request beats the D-cache once the D-cache has had its streak.
   assign w_ic_grant    = ic_req_i & ~ic_abort_i & (~dc_req_i | w_streak_full);
   assign w_beat_last   = (r_beat == IDX_W'(BLOCK_WORDS - 1));
   assign w_beat_addr   = r_line_base | {{(ADDR_W-OFF_W){1'b0}}, r_beat, 2'b00};
   assign w_ic_beat_ok  = (r_state == IC_BURST) & mem_ack_i & ~ic_abort_i;
   assign w_unused      = ^{ic_addr_i[OFF_W-1:0], dc_addr_i[1:0]};

   assign mem_req_o     = (r_state != IDLE);
   assign mem_we_o      = (r_state == DC_XFER) & r_dc_we;
   assign mem_wdata_o   = (r_state == DC_XFER) ? r_dc_wdata : '0;
   assign ic_rvalid_o   = w_ic_beat_ok;
   assign ic_word_idx_o = w_ic_beat_ok ? r_beat : '0;
   assign ic_done_o     = w_ic_beat_ok & w_beat_last;
   assign dc_done_o     = (r_state == DC_XFER) & mem_ack_i;
   assign rdata_o       = mem_rdata_i;

   always_comb begin
      mem_addr_o = '0;
      case (r_state)
         IC_BURST, IC_ABORT: mem_addr_o = w_beat_addr;
         DC_XFER:            mem_addr_o = r_dc_addr;
         default:            mem_addr_o = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= IDLE;
         r_beat      <= '0;
         r_streak    <= '0;
         r_line_base <= '0;
         r_dc_addr   <= '0;
         r_dc_we     <= 1'b0;
         r_dc_wdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_ic_grant) begin
                  r_line_base <= {ic_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  r_beat      <= '0;
                  r_streak    <= '0;
                  r_state     <= IC_BURST;
               end else if (dc_req_i) begin
                  r_dc_addr  <= {dc_addr_i[ADDR_W-1:2], 2'b00};
                  r_dc_we    <= dc_we_i;
                  r_dc_wdata <= dc_wdata_i;
                  r_state    <= DC_XFER;
                  if (!ic_req_i)
                     r_streak <= '0;
                  else if (!w_streak_full)
                     r_streak <= r_streak + STREAK_W'(1);
               end
            end
            // An abort may not retract a raised request; it only discards the beat.
            IC_BURST: begin
               if (ic_abort_i) begin
                  if (mem_ack_i) begin
                     r_beat  <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_state <= IC_ABORT;
                  end
               end else if (mem_ack_i) begin
                  if (w_beat_last) begin
                     r_beat  <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_beat <= r_beat + IDX_W'(1);
                  end
               end
            end
            IC_ABORT: begin
               if (mem_ack_i) begin
                  r_beat  <= '0;
                  r_state <= IDLE;
               end
            end
            DC_XFER: begin
               if (mem_ack_i)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed vector table, hand sequences
// for streak/abort/reset corners, and randomized traffic against a reference model.
module tb_l1_mem_arbiter;

   localparam int BW   = 4;
   localparam int MAXS = 4;

   logic        clk_i = 1'b0;
   logic        reset_n_i = 1'b1;
   logic        ic_req_i = 1'b0;
   logic [31:0] ic_addr_i = '0;
   logic        ic_abort_i = 1'b0;
   logic        ic_rvalid_o;
   logic [1:0]  ic_word_idx_o;
   logic        ic_done_o;
   logic        dc_req_i = 1'b0;
   logic        dc_we_i = 1'b0;
   logic [31:0] dc_addr_i = '0;
   logic [31:0] dc_wdata_i = '0;
   logic        dc_done_o;
   logic [31:0] rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int nChecks = 0;
   int nFail   = 0;

   l1_mem_arbiter #(
      .BLOCK_WORDS(BW), .ADDR_W(32), .DATA_W(32), .MAX_DC_STREAK(MAXS)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_abort_i(ic_abort_i),
      .ic_rvalid_o(ic_rvalid_o), .ic_word_idx_o(ic_word_idx_o), .ic_done_o(ic_done_o),
      .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
      .dc_wdata_i(dc_wdata_i), .dc_done_o(dc_done_o), .rdata_o(rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        icReq;
      logic [31:0] icAddr;
      logic        icAbort;
      logic        dcReq;
      logic        dcWe;
      logic [31:0] dcAddr;
      logic [31:0] dcWdata;
      logic        memAck;
      logic [31:0] memRdata;
      logic        expReq;
      logic        expWe;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
      logic        expRvalid;
      logic [1:0]  expIdx;
      logic        expIcDone;
      logic        expDcDone;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(
      logic icReq, logic [31:0] icAddr, logic icAbort,
      logic dcReq, logic dcWe, logic [31:0] dcAddr, logic [31:0] dcWdata,
      logic memAck, logic [31:0] memRdata,
      logic expReq, logic expWe, logic [31:0] expAddr, logic [31:0] expWdata,
      logic expRvalid, logic [1:0] expIdx, logic expIcDone, logic expDcDone);
      vec_t v;
      v = '{icReq, icAddr, icAbort, dcReq, dcWe, dcAddr, dcWdata, memAck, memRdata,
            expReq, expWe, expAddr, expWdata, expRvalid, expIdx, expIcDone, expDcDone};
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      ic_req_i    = v.icReq;
      ic_addr_i   = v.icAddr;
      ic_abort_i  = v.icAbort;
      dc_req_i    = v.dcReq;
      dc_we_i     = v.dcWe;
      dc_addr_i   = v.dcAddr;
      dc_wdata_i  = v.dcWdata;
      mem_ack_i   = v.memAck;
      mem_rdata_i = v.memRdata;
   endtask

   task automatic driveIdle();
      applyStimulus('0);
   endtask

   // Directed rows: lone refill, D-vs-I collision, abort with stalled ack, abort corners.
   task automatic buildTable();
      // lone I-cache miss at 0x104C, ack every cycle
      vecs.push_back(mkVec(1, 32'h104C, 0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h104C, 0, 0, 0, 0, 0, 1, 32'h22, 1, 0, 32'h1040, 0, 1, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h104C, 0, 0, 0, 0, 0, 1, 32'h33, 1, 0, 32'h1044, 0, 1, 1, 0, 0));
      vecs.push_back(mkVec(1, 32'h104C, 0, 0, 0, 0, 0, 1, 32'h44, 1, 0, 32'h1048, 0, 1, 2, 0, 0));
      vecs.push_back(mkVec(1, 32'h104C, 0, 0, 0, 0, 0, 1, 32'h55, 1, 0, 32'h104C, 0, 1, 3, 1, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0));
      // simultaneous I and D requests: D first, one idle cycle, then the burst
      vecs.push_back(mkVec(1, 32'h3000, 0, 1, 0, 32'h2000, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h3000, 0, 1, 0, 32'h2000, 0, 1, 32'h88, 1, 0, 32'h2000, 0, 0, 0, 0, 1));
      vecs.push_back(mkVec(1, 32'h3000, 0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h3000, 0, 0, 0, 0, 0, 1, 32'hA1, 1, 0, 32'h3000, 0, 1, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h3000, 0, 0, 0, 0, 0, 1, 32'hA2, 1, 0, 32'h3004, 0, 1, 1, 0, 0));
      vecs.push_back(mkVec(1, 32'h3000, 0, 0, 0, 0, 0, 1, 32'hA3, 1, 0, 32'h3008, 0, 1, 2, 0, 0));
      vecs.push_back(mkVec(1, 32'h3000, 0, 0, 0, 0, 0, 1, 32'hA4, 1, 0, 32'h300C, 0, 1, 3, 1, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 32'hA5, 0, 0, 0, 0, 0, 0, 0, 0));
      // abort on beat 1 with ack held low for 3 cycles, then a D-cache write
      vecs.push_back(mkVec(1, 32'h7000, 0, 0, 0, 0, 0, 0, 32'hB1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h7000, 0, 0, 0, 0, 0, 1, 32'hB2, 1, 0, 32'h7000, 0, 1, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h7000, 1, 0, 0, 0, 0, 0, 32'hB3, 1, 0, 32'h7004, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 1, 1, 32'h2040, 32'hDEAD, 0, 32'hB4, 1, 0, 32'h7004, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 1, 1, 32'h2040, 32'hDEAD, 0, 32'hB5, 1, 0, 32'h7004, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 1, 1, 32'h2040, 32'hDEAD, 1, 32'hB6, 1, 0, 32'h7004, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 1, 1, 32'h2040, 32'hDEAD, 1, 32'hB7, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 1, 1, 32'h2040, 32'hDEAD, 1, 32'hB8, 1, 1, 32'h2040, 32'hDEAD, 0, 0, 0, 1));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 32'hB9, 0, 0, 0, 0, 0, 0, 0, 0));
      // abort in IDLE blocks the grant; abort together with ack drops the beat
      vecs.push_back(mkVec(1, 32'h8000, 1, 0, 0, 0, 0, 1, 32'hC1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 32'hC2, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h8000, 0, 0, 0, 0, 0, 0, 32'hC3, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 32'h8000, 1, 0, 0, 0, 0, 1, 32'hC4, 1, 0, 32'h8000, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 32'hC5, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic runTable();
      for (int i = 0; i < vecs.size(); i++) begin
         tick();
         applyStimulus(vecs[i]);
         @(negedge clk_i);
         checkOutput($sformatf("v%0d_mem_req", i), mem_req_o, vecs[i].expReq);
         if (vecs[i].expReq) begin
            checkOutput($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].expAddr);
            checkOutput($sformatf("v%0d_mem_we", i), mem_we_o, vecs[i].expWe);
            if (vecs[i].expWe)
               checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].expWdata);
         end
         checkOutput($sformatf("v%0d_ic_rvalid", i), ic_rvalid_o, vecs[i].expRvalid);
         if (vecs[i].expRvalid)
            checkOutput($sformatf("v%0d_ic_idx", i), ic_word_idx_o, vecs[i].expIdx);
         checkOutput($sformatf("v%0d_ic_done", i), ic_done_o, vecs[i].expIcDone);
         checkOutput($sformatf("v%0d_dc_done", i), dc_done_o, vecs[i].expDcDone);
         checkOutput($sformatf("v%0d_rdata", i), rdata_o, vecs[i].memRdata);
      end
   endtask

   task automatic resetMidBurst();
      vec_t v;
      v = mkVec(1, 32'hA000, 0, 0, 0, 0, 0, 1, 32'h5A, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); applyStimulus(v);
      tick(); applyStimulus(v);
      tick(); applyStimulus(v);
      #1;
      checkOutput("pre_reset_rvalid", ic_rvalid_o, 1);
      #2 reset_n_i = 1'b0;
      #1;
      checkOutput("rst_async_mem_req", mem_req_o, 0);
      checkOutput("rst_async_rvalid", ic_rvalid_o, 0);
      checkOutput("rst_async_ic_done", ic_done_o, 0);
      driveIdle();
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         @(negedge clk_i);
         checkOutput($sformatf("post_rst_mem_req_%0d", k), mem_req_o, 0);
         checkOutput($sformatf("post_rst_ic_done_%0d", k), ic_done_o, 0);
         checkOutput($sformatf("post_rst_dc_done_%0d", k), dc_done_o, 0);
      end
   endtask

   // With both requesters held, the D-cache gets exactly MAXS grants before the burst.
   task automatic streakRound(input string tag);
      int cnt = 0;
      bit seenIc = 0;
      bit finished = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         ic_req_i = 1; ic_addr_i = 32'h5008; ic_abort_i = 0;
         dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h2200; dc_wdata_i = 0;
         mem_ack_i = 1; mem_rdata_i = 32'(k);
         @(negedge clk_i);
         if (dc_done_o && !seenIc) cnt++;
         if (ic_rvalid_o) seenIc = 1;
         if (ic_done_o) begin
            finished = 1;
            break;
         end
      end
      checkOutput({tag, "_dc_grants"}, 64'(cnt), 64'(MAXS));
      checkOutput({tag, "_ic_burst_done"}, finished, 1);
   endtask

   task automatic burstWithStalls();
      int acks = 0;
      bit icDone = 0;
      bit dcDone = 0;
      logic [31:0] eAddr;
      for (int i = 0; i < 80; i++) begin
         tick();
         ic_req_i = !icDone; ic_addr_i = 32'h9004; ic_abort_i = 0;
         dc_req_i = (i >= 1) && !dcDone; dc_we_i = 0; dc_addr_i = 32'h2300; dc_wdata_i = 0;
         mem_ack_i = (i % 3 == 0); mem_rdata_i = 32'h1000 + 32'(i);
         @(negedge clk_i);
         if (mem_req_o) begin
            eAddr = icDone ? 32'h2300 : 32'h9000 + 32'(4 * acks);
            checkOutput($sformatf("stall_addr_c%0d", i), mem_addr_o, eAddr);
            if (!icDone && mem_ack_i) acks++;
         end
         if (dc_done_o) begin
            dcDone = 1;
            checkOutput("dc_after_ic_done", icDone, 1);
         end
         if (ic_done_o) icDone = 1;
         if (dcDone) break;
      end
      checkOutput("dc_served_after_burst", dcDone, 1);
   endtask

   // Reference model: who owns the bus, how many words of the line are done, D-cache wins.
   logic        mIc, mDrain, mDc, mDcWe;
   int          mWords, mStreak;
   logic [31:0] mLine, mDcAddr, mDcData;

   task automatic modelCheckAndStep(input int c);
      logic        eReq, eRv, eIcD, eDcD, icWants;
      logic [31:0] eAddr;
      eReq  = mIc || mDrain || mDc;
      eAddr = mDc ? mDcAddr : mLine + 32'(4 * mWords);
      eRv   = mIc && mem_ack_i && !ic_abort_i;
      eIcD  = eRv && (mWords == BW - 1);
      eDcD  = mDc && mem_ack_i;
      checkOutput($sformatf("rnd%0d_mem_req", c), mem_req_o, eReq);
      if (eReq) begin
         checkOutput($sformatf("rnd%0d_mem_addr", c), mem_addr_o, eAddr);
         checkOutput($sformatf("rnd%0d_mem_we", c), mem_we_o, mDc && mDcWe);
         if (mDc && mDcWe)
            checkOutput($sformatf("rnd%0d_mem_wdata", c), mem_wdata_o, mDcData);
      end
      checkOutput($sformatf("rnd%0d_ic_rvalid", c), ic_rvalid_o, eRv);
      if (eRv)
         checkOutput($sformatf("rnd%0d_ic_idx", c), ic_word_idx_o, 64'(mWords));
      checkOutput($sformatf("rnd%0d_ic_done", c), ic_done_o, eIcD);
      checkOutput($sformatf("rnd%0d_dc_done", c), dc_done_o, eDcD);
      checkOutput($sformatf("rnd%0d_rdata", c), rdata_o, mem_rdata_i);
      if (mIc) begin
         if (ic_abort_i) begin
            mIc = 0;
            mDrain = !mem_ack_i;
         end else if (mem_ack_i) begin
            mWords++;
            if (mWords == BW) mIc = 0;
         end
      end else if (mDrain) begin
         if (mem_ack_i) mDrain = 0;
      end else if (mDc) begin
         if (mem_ack_i) mDc = 0;
      end else begin
         icWants = ic_req_i && !ic_abort_i;
         if (icWants && (!dc_req_i || mStreak == MAXS)) begin
            mIc = 1;
            mWords = 0;
            mLine = (ic_addr_i / (BW * 4)) * (BW * 4);
            mStreak = 0;
         end else if (dc_req_i) begin
            mDc = 1;
            mDcAddr = (dc_addr_i / 4) * 4;
            mDcWe = dc_we_i;
            mDcData = dc_wdata_i;
            mStreak = ic_req_i ? ((mStreak < MAXS) ? mStreak + 1 : MAXS) : 0;
         end
      end
   endtask

   task automatic randomTraffic(input int cycles);
      bit icPending = 0, dcPending = 0, lastIcDone = 0, lastDcDone = 0, lastAbort = 0;
      logic [31:0] icAddrR = '0, dcAddrR = '0, dcWdR = '0;
      logic dcWeR = 0;
      mIc = 0; mDrain = 0; mDc = 0; mDcWe = 0;
      mWords = 0; mStreak = 0; mLine = '0; mDcAddr = '0; mDcData = '0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (lastIcDone || lastAbort) icPending = 0;
         if (lastDcDone) dcPending = 0;
         if (!icPending && $urandom_range(3) == 0) begin
            icPending = 1;
            icAddrR = $urandom & 32'h0003_FFFF;
         end
         if (!dcPending && $urandom_range(2) == 0) begin
            dcPending = 1;
            dcWeR = 1'($urandom_range(1));
            dcAddrR = $urandom & 32'h0003_FFFC;
            dcWdR = $urandom;
         end
         ic_req_i = icPending; ic_addr_i = icAddrR;
         ic_abort_i = ($urandom_range(15) == 0);
         dc_req_i = dcPending; dc_we_i = dcWeR; dc_addr_i = dcAddrR; dc_wdata_i = dcWdR;
         mem_ack_i = ($urandom_range(2) != 0);
         mem_rdata_i = $urandom;
         @(negedge clk_i);
         modelCheckAndStep(c);
         lastIcDone = ic_done_o;
         lastDcDone = dc_done_o;
         lastAbort = ic_abort_i;
         if (nFail > 40) break;
      end
   endtask

   initial begin
      #2 reset_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset_mem_req", mem_req_o, 0);
      checkOutput("reset_mem_we", mem_we_o, 0);
      checkOutput("reset_mem_addr", mem_addr_o, 0);
      checkOutput("reset_mem_wdata", mem_wdata_o, 0);
      checkOutput("reset_ic_rvalid", ic_rvalid_o, 0);
      checkOutput("reset_ic_idx", ic_word_idx_o, 0);
      checkOutput("reset_ic_done", ic_done_o, 0);
      checkOutput("reset_dc_done", dc_done_o, 0);
      checkOutput("reset_rdata", rdata_o, 0);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;

      buildTable();
      runTable();
      resetMidBurst();
      streakRound("streak1");
      streakRound("streak2");
      burstWithStalls();

      tick();
      driveIdle();
      reset_n_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      randomTraffic(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #1000000;
      nChecks++;
      nFail++;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
